// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// writeback/ALU selects and per-class instruction latencies.
package mcu_pkg;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_IRMOV = 8'h10;
  localparam logic [7:0] OP_ADD   = 8'h20;
  localparam logic [7:0] OP_SUB   = 8'h21;
  localparam logic [7:0] OP_LW    = 8'h40;
  localparam logic [7:0] OP_SW    = 8'h41;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_IMM = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_ADDI = 2'd2;

  // Cycles from FETCH up to and including the retire cycle.
  localparam int LAT_NOP = 2;
  localparam int LAT_ALU = 4;
  localparam int LAT_SW  = 4;
  localparam int LAT_LW  = 5;

endpackage

// File: rtl/mc_control_unit_if.sv
// Control-unit bus: run/instruction inputs plus datapath strobes.
// MCU_PERFCNT_EN adds the cycle_cnt/retire_cnt performance counters.
interface mc_control_unit_if #(
  parameter int ADDR_W = 9,
  parameter int REG_AW = 4
);
  logic              working;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir;
  logic [REG_AW-1:0] rf_raddr_a;
  logic [REG_AW-1:0] rf_raddr_b;
  logic [REG_AW-1:0] rf_waddr;
  logic              rf_we;
  logic [1:0]        wb_sel;
  logic [1:0]        alu_op;
  logic              dm_re;
  logic              dm_we;
  logic              busy;
  logic              halted;
  logic              illegal;
  logic              retire;
`ifdef MCU_PERFCNT_EN
  logic [31:0]       cycle_cnt;
  logic [31:0]       retire_cnt;

  modport master (
    input  working, instr,
    output pc, ir, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, wb_sel, alu_op,
           dm_re, dm_we, busy, halted, illegal, retire, cycle_cnt, retire_cnt
  );
  modport slave (
    output working, instr,
    input  pc, ir, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, wb_sel, alu_op,
           dm_re, dm_we, busy, halted, illegal, retire, cycle_cnt, retire_cnt
  );
`else
  modport master (
    input  working, instr,
    output pc, ir, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, wb_sel, alu_op,
           dm_re, dm_we, busy, halted, illegal, retire
  );
  modport slave (
    output working, instr,
    input  pc, ir, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, wb_sel, alu_op,
           dm_re, dm_we, busy, halted, illegal, retire
  );
`endif
endinterface

// File: rtl/mcu_decoder.sv
// Opcode classifier for the latched IR; purely combinational.
module mcu_decoder
  import mcu_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       is_nop,
  output logic       is_irmov,
  output logic       is_alu,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_halt,
  output logic       is_illegal,
  output logic       dest_sel
);

  always_comb begin
    is_nop     = 1'b0;
    is_irmov   = 1'b0;
    is_alu     = 1'b0;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_NOP:         is_nop   = 1'b1;
      OP_IRMOV:       is_irmov = 1'b1;
      OP_ADD, OP_SUB: is_alu   = 1'b1;
      OP_LW:          is_lw    = 1'b1;
      OP_SW:          is_sw    = 1'b1;
      OP_HALT:        is_halt  = 1'b1;
      default:        is_illegal = 1'b1;
    endcase
    // IRMOV is the only class that writes rB rather than rA.
    dest_sel = is_irmov;
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle sequencer: fetch, decode and strobe generation, one instruction at a time.
// Optional MCU_PERFCNT_EN adds busy-cycle and retire counters.
//
// state  | meaning
// IDLE   | stopped, pc held; leaves when working=1
// FETCH  | ir <= instr, pc <= pc+1
// DECODE | classify ir; NOP retires here, HALT/illegal go to HALT
// EXEC   | ALU phase (address generation for LW/SW)
// MEM    | data-memory access; SW retires here
// WB     | register-file write and retire
// HALT   | absorbing until rst_n
module mc_control_unit
  import mcu_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int REG_AW = 4
) (
  input  logic clock,
  input  logic rst_n,
  mc_control_unit_if.master bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       ir_q;
  logic              illegal_q;

  logic is_nop, is_irmov, is_alu, is_lw, is_sw, is_halt, is_illegal, dest_sel;
  logic ir_load, illegal_set;
  logic rf_we, dm_re, dm_we, retire, busy;
  logic [1:0] wb_sel, alu_op, op_sel;
  logic [REG_AW-1:0] rf_waddr;
  state_t boundary;

  mcu_decoder u_decoder (
    .opcode     (ir_q[31:24]),
    .is_nop     (is_nop),
    .is_irmov   (is_irmov),
    .is_alu     (is_alu),
    .is_lw      (is_lw),
    .is_sw      (is_sw),
    .is_halt    (is_halt),
    .is_illegal (is_illegal),
    .dest_sel   (dest_sel)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ir_load) begin
        ir_q <= bus.instr;
        pc_q <= pc_q + ADDR_W'(1);
      end
      if (illegal_set) illegal_q <= 1'b1;
    end
  end

  // ADD and SUB differ only in opcode bit 0.
  always_comb begin
    op_sel = ALU_ADD;
    if (is_lw || is_sw)        op_sel = ALU_ADDI;
    else if (is_alu && ir_q[24]) op_sel = ALU_SUB;
  end

  always_comb begin
    state_d     = state_q;
    ir_load     = 1'b0;
    illegal_set = 1'b0;
    rf_we       = 1'b0;
    dm_re       = 1'b0;
    dm_we       = 1'b0;
    retire      = 1'b0;
    wb_sel      = WB_ALU;
    alu_op      = ALU_ADD;
    rf_waddr    = '0;
    boundary    = bus.working ? ST_FETCH : ST_IDLE;
    case (state_q)
      ST_IDLE: if (bus.working) state_d = ST_FETCH;
      ST_FETCH: begin
        ir_load = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (is_nop) begin
          retire  = 1'b1;
          state_d = boundary;
        end else if (is_halt) begin
          state_d = ST_HALT;
        end else if (is_illegal) begin
          illegal_set = 1'b1;
          state_d     = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_op  = op_sel;
        state_d = (is_lw || is_sw) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        alu_op = op_sel;
        if (is_lw) begin
          dm_re   = 1'b1;
          state_d = ST_WB;
        end else begin
          dm_we   = 1'b1;
          retire  = 1'b1;
          state_d = boundary;
        end
      end
      ST_WB: begin
        alu_op   = op_sel;
        rf_we    = 1'b1;
        rf_waddr = dest_sel ? REG_AW'(ir_q[19:16]) : REG_AW'(ir_q[23:20]);
        wb_sel   = is_irmov ? WB_IMM : (is_lw ? WB_MEM : WB_ALU);
        retire   = 1'b1;
        state_d  = boundary;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE) && (state_q != ST_HALT);

  assign bus.pc         = pc_q;
  assign bus.ir         = ir_q;
  assign bus.rf_raddr_a = REG_AW'(ir_q[23:20]);
  assign bus.rf_raddr_b = REG_AW'(ir_q[19:16]);
  assign bus.rf_waddr   = rf_waddr;
  assign bus.rf_we      = rf_we;
  assign bus.wb_sel     = wb_sel;
  assign bus.alu_op     = alu_op;
  assign bus.dm_re      = dm_re;
  assign bus.dm_we      = dm_we;
  assign bus.busy       = busy;
  assign bus.halted     = (state_q == ST_HALT);
  assign bus.illegal    = illegal_q;
  assign bus.retire     = retire;

`ifdef MCU_PERFCNT_EN
  logic [31:0] cycle_cnt_q, retire_cnt_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_q + 32'(busy);
      retire_cnt_q <= retire_cnt_q + 32'(retire);
    end
  end

  assign bus.cycle_cnt  = cycle_cnt_q;
  assign bus.retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: per-cycle comparison against a
// latency-table instruction model plus directed literal checks.
module tb_mc_control_unit;
  import mcu_pkg::*;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic working = 1'b0;
  always #5 clock = ~clock;

  mc_control_unit_if #(.ADDR_W(9), .REG_AW(4)) bus ();
  mc_control_unit #(.ADDR_W(9), .REG_AW(4)) dut (.clock(clock), .rst_n(rst_n), .bus(bus));

  logic [31:0] imem [512];
  assign bus.instr   = imem[bus.pc];
  assign bus.working = working;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 running (phase 1 = fetch cycle), 2 halted.
  int          m_mode  = 0;
  int          m_phase = 0;
  logic [31:0] m_ir    = '0;
  logic [8:0]  m_pc    = '0;
  logic        m_ill   = 1'b0;
  logic [31:0] m_cyc   = '0;
  logic [31:0] m_ret   = '0;

  function automatic int lat_of(input logic [7:0] op);
    case (op)
      OP_NOP:                 return LAT_NOP;
      OP_IRMOV, OP_ADD, OP_SUB: return LAT_ALU;
      OP_SW:                  return LAT_SW;
      OP_LW:                  return LAT_LW;
      default:                return 2;
    endcase
  endfunction

  function automatic logic legal(input logic [7:0] op);
    return op inside {OP_NOP, OP_IRMOV, OP_ADD, OP_SUB, OP_LW, OP_SW, OP_HALT};
  endfunction

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_phase <= 0; m_ir <= '0; m_pc <= '0;
      m_ill <= 1'b0; m_cyc <= '0; m_ret <= '0;
    end else begin
      if (m_mode == 1) m_cyc <= m_cyc + 1;
      if (m_mode == 0) begin
        if (working) begin m_mode <= 1; m_phase <= 1; end
      end else if (m_mode == 1) begin
        if (m_phase == 1) begin
          m_ir    <= imem[m_pc];
          m_pc    <= m_pc + 9'd1;
          m_phase <= 2;
        end else if (m_phase == 2 && (m_ir[31:24] == OP_HALT || !legal(m_ir[31:24]))) begin
          m_mode <= 2;
          if (!legal(m_ir[31:24])) m_ill <= 1'b1;
        end else if (m_phase == lat_of(m_ir[31:24])) begin
          m_ret <= m_ret + 1;
          if (working) m_phase <= 1;
          else m_mode <= 0;
        end else begin
          m_phase <= m_phase + 1;
        end
      end
    end
  end

  logic [7:0] c_op;
  logic       c_run, c_fin, c_we;
  logic [3:0] c_waddr;
  logic [1:0] c_wb, c_alu;

  always @(negedge clock) begin
    c_op   = m_ir[31:24];
    c_run  = (m_mode == 1);
    c_fin  = c_run && m_phase >= 2 && m_phase == lat_of(c_op) && legal(c_op) && c_op != OP_HALT;
    c_we   = c_fin && (c_op inside {OP_IRMOV, OP_ADD, OP_SUB, OP_LW});
    c_waddr = c_we ? ((c_op == OP_IRMOV) ? m_ir[19:16] : m_ir[23:20]) : 4'd0;
    c_wb   = !c_we ? 2'd0 : (c_op == OP_IRMOV) ? 2'd1 : (c_op == OP_LW) ? 2'd2 : 2'd0;
    c_alu  = !(c_run && m_phase >= 3) ? 2'd0 :
             (c_op == OP_SUB) ? 2'd1 : (c_op inside {OP_LW, OP_SW}) ? 2'd2 : 2'd0;
    chk("m_pc", 32'(bus.pc), 32'(m_pc));
    chk("m_ir", bus.ir, m_ir);
    chk("m_raddr_a", 32'(bus.rf_raddr_a), 32'(m_ir[23:20]));
    chk("m_raddr_b", 32'(bus.rf_raddr_b), 32'(m_ir[19:16]));
    chk("m_busy", 32'(bus.busy), 32'(c_run));
    chk("m_halted", 32'(bus.halted), 32'(m_mode == 2));
    chk("m_illegal", 32'(bus.illegal), 32'(m_ill));
    chk("m_retire", 32'(bus.retire), 32'(c_fin));
    chk("m_rf_we", 32'(bus.rf_we), 32'(c_we));
    chk("m_rf_waddr", 32'(bus.rf_waddr), 32'(c_waddr));
    chk("m_wb_sel", 32'(bus.wb_sel), 32'(c_wb));
    chk("m_alu_op", 32'(bus.alu_op), 32'(c_alu));
    chk("m_dm_re", 32'(bus.dm_re), 32'(c_run && c_op == OP_LW && m_phase == 4));
    chk("m_dm_we", 32'(bus.dm_we), 32'(c_run && c_op == OP_SW && m_phase == 4));
`ifdef MCU_PERFCNT_EN
    chk("m_cycle_cnt", bus.cycle_cnt, m_cyc);
    chk("m_retire_cnt", bus.retire_cnt, m_ret);
`endif
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    working = 1'b0;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 512; i++) imem[i] = 32'h0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic wait_not_busy(input int budget);
    int i;
    i = 0;
    while (bus.busy && i < budget) begin
      cyc(1);
      i++;
    end
    chk("wait_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) imem[i] = 32'h0;

    // Reset state and single IRMOV
    do_reset();
    chk("rst_pc", 32'(bus.pc), 32'd0);
    chk("rst_ir", bus.ir, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    imem[0] = 32'h10F1000A;
    working = 1'b1;
    cyc(1);
    chk("irmov_fetch_busy", 32'(bus.busy), 32'd1);
    chk("irmov_fetch_pc", 32'(bus.pc), 32'd0);
    working = 1'b0;
    cyc(3);
    chk("irmov_rf_we", 32'(bus.rf_we), 32'd1);
    chk("irmov_waddr", 32'(bus.rf_waddr), 32'd1);
    chk("irmov_wb_sel", 32'(bus.wb_sel), 32'd1);
    chk("irmov_retire", 32'(bus.retire), 32'd1);
    chk("irmov_pc", 32'(bus.pc), 32'd1);
    cyc(1);
    chk("irmov_idle", 32'(bus.busy), 32'd0);

    // ADD then SUB
    do_reset();
    imem[0] = 32'h20150000;
    imem[1] = 32'h21150000;
    working = 1'b1;
    cyc(4);
    chk("add_retire", 32'(bus.retire), 32'd1);
    chk("add_waddr", 32'(bus.rf_waddr), 32'd1);
    chk("add_alu_op", 32'(bus.alu_op), 32'd0);
    cyc(1);
    chk("sub_fetch_pc", 32'(bus.pc), 32'd1);
    working = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("gap_retire", 32'(bus.retire), 32'd0);
      cyc(1);
    end
    chk("sub_retire", 32'(bus.retire), 32'd1);
    chk("sub_alu_op", 32'(bus.alu_op), 32'd1);
    chk("sub_waddr", 32'(bus.rf_waddr), 32'd1);
    cyc(1);
    chk("sub_idle_pc", 32'(bus.pc), 32'd2);

    // SW then LW
    do_reset();
    imem[0] = 32'h41000065;
    imem[1] = 32'h40300065;
    working = 1'b1;
    cyc(3);
    chk("sw_exec_alu", 32'(bus.alu_op), 32'd2);
    cyc(1);
    chk("sw_dm_we", 32'(bus.dm_we), 32'd1);
    chk("sw_alu_op", 32'(bus.alu_op), 32'd2);
    chk("sw_no_rf_we", 32'(bus.rf_we), 32'd0);
    chk("sw_retire", 32'(bus.retire), 32'd1);
    cyc(1);
    working = 1'b0;
    cyc(3);
    chk("lw_dm_re", 32'(bus.dm_re), 32'd1);
    chk("lw_mem_alu", 32'(bus.alu_op), 32'd2);
    chk("lw_mem_no_we", 32'(bus.rf_we), 32'd0);
    cyc(1);
    chk("lw_rf_we", 32'(bus.rf_we), 32'd1);
    chk("lw_wb_sel", 32'(bus.wb_sel), 32'd2);
    chk("lw_waddr", 32'(bus.rf_waddr), 32'd3);
    chk("lw_retire", 32'(bus.retire), 32'd1);

    // Illegal opcode halts
    do_reset();
    imem[2] = 32'h7A000000;
    working = 1'b1;
    cyc(2);
    chk("nop_retire", 32'(bus.retire), 32'd1);
    cyc(5);
    chk("ill_illegal", 32'(bus.illegal), 32'd1);
    chk("ill_halted", 32'(bus.halted), 32'd1);
    chk("ill_busy", 32'(bus.busy), 32'd0);
    chk("ill_pc", 32'(bus.pc), 32'd3);
    for (int k = 0; k < 4; k++) begin
      working = ~working;
      cyc(1);
    end
    chk("halt_stays", 32'(bus.halted), 32'd1);
    chk("halt_pc", 32'(bus.pc), 32'd3);
    working = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("halt_rst_illegal", 32'(bus.illegal), 32'd0);
    chk("halt_rst_halted", 32'(bus.halted), 32'd0);
    chk("halt_rst_pc", 32'(bus.pc), 32'd0);

    // Drop working mid-instruction, then resume
    do_reset();
    imem[4] = 32'h20150000;
    imem[5] = 32'h10F2000B;
    working = 1'b1;
    cyc(11);
    chk("drop_exec_pc", 32'(bus.pc), 32'd5);
    working = 1'b0;
    cyc(1);
    chk("drop_retire", 32'(bus.retire), 32'd1);
    cyc(1);
    chk("drop_idle", 32'(bus.busy), 32'd0);
    chk("drop_idle_pc", 32'(bus.pc), 32'd5);
    working = 1'b1;
    cyc(1);
    chk("resume_pc", 32'(bus.pc), 32'd5);
    working = 1'b0;
    cyc(1);
    chk("resume_ir", bus.ir, 32'h10F2000B);
    cyc(2);
    chk("resume_waddr", 32'(bus.rf_waddr), 32'd2);
    wait_not_busy(5);
    chk("resume_end_pc", 32'(bus.pc), 32'd6);

    // Reset during SW memory cycle
    do_reset();
    imem[0] = 32'h41000065;
    working = 1'b1;
    cyc(1);
    working = 1'b0;
    cyc(3);
    chk("abort_dm_we_pre", 32'(bus.dm_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_dm_we", 32'(bus.dm_we), 32'd0);
    chk("abort_pc", 32'(bus.pc), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_retire", 32'(bus.retire), 32'd0);
`ifdef MCU_PERFCNT_EN
    chk("abort_retire_cnt", bus.retire_cnt, 32'd0);
`endif

    // PC wraps after 512 NOPs
    do_reset();
    working = 1'b1;
    cyc(1022);
    chk("wrap_pc_511", 32'(bus.pc), 32'd511);
    cyc(2);
    chk("wrap_pc_0", 32'(bus.pc), 32'd0);
    working = 1'b0;
    wait_not_busy(5);
`ifdef MCU_PERFCNT_EN
    chk("wrap_retire_cnt", bus.retire_cnt, 32'd512);
    chk("wrap_cycle_cnt", bus.cycle_cnt, 32'd1024);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
